ws2811_hsv_pattern_engine: RTL and testbench

Parametrised colour-pattern source for the WS2811 LED chain. Generates a fully saturated hue wave (six-sector trapezoidal R/G/B ramps) and serves one colour per pixel on request from the serialiser. Adds a per-pixel hue offset (moving rainbow), global brightness scaling, a breathing mode and a configurable strip length. Sits between the timebase/control logic and the WS2811 bit serialiser.

---
 rtl/ws2811_hsv_pattern_engine_pkg.sv | 19 +
 rtl/ws2811_hsv_pattern_engine_if.sv | 29 ++
 rtl/ws2811_hsv_pattern_engine_hue_to_rgb.sv | 28 ++
 rtl/ws2811_hsv_pattern_engine.sv | 117 +++++++++++
 tb/tb_ws2811_hsv_pattern_engine.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/ws2811_hsv_pattern_engine_pkg.sv
// ws2811_pkg: shared colour-source types, mode encodings and hue arithmetic helpers.
// No ports; imported by the pattern engine and its hue-to-RGB converter.
package ws2811_pkg;
  typedef enum logic [1:0] {
    MODE_RAINBOW = 2'b00,
    MODE_UNIFORM = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_OFF     = 2'b11
  } mode_e;
  typedef enum logic {BR_UP, BR_DOWN} breath_e;
  localparam int unsigned SECTORS = 6;
  typedef logic [2:0] sector_t;
  // Sector part of a hue addition; operands are < 6, so one subtraction always wraps.
  function automatic sector_t hue_add(sector_t a, sector_t b, logic cin);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b} + {3'b000, cin};
    return (s >= 4'(SECTORS)) ? sector_t'(s - 4'(SECTORS)) : sector_t'(s);
  endfunction
endpackage

// File: rtl/ws2811_hsv_pattern_engine_if.sv
// ws2811_hsv_pattern_engine_if: control/request inputs and pixel outputs of the pattern engine.
// master: timebase/serialiser side (drives advance, serial_reset, pixel_req, mode, period,
//         pixel_step, brightness; receives rgb, rgb_valid, pixel_index).
// slave:  pattern engine side.
interface ws2811_hsv_pattern_engine_if #(
  parameter int COLOR_W = 8,
  parameter int DIV_W   = 32,
  parameter int N_LEDS  = 50
);
  localparam int IDX_W = $clog2(N_LEDS + 1);
  logic                 advance;
  logic                 serial_reset;
  logic                 pixel_req;
  logic [1:0]           mode;
  logic [DIV_W-1:0]     period;
  logic [3+COLOR_W-1:0] pixel_step;
  logic [COLOR_W-1:0]   brightness;
  logic [3*COLOR_W-1:0] rgb;
  logic                 rgb_valid;
  logic [IDX_W-1:0]     pixel_index;
  modport master (
    output advance, serial_reset, pixel_req, mode, period, pixel_step, brightness,
    input  rgb, rgb_valid, pixel_index
  );
  modport slave (
    input  advance, serial_reset, pixel_req, mode, period, pixel_step, brightness,
    output rgb, rgb_valid, pixel_index
  );
endinterface

// File: rtl/ws2811_hsv_pattern_engine_hue_to_rgb.sv
// ws2811_hue_to_rgb: fully saturated hue {sector, frac} to packed {r,g,b} trapezoid ramps.
// sector_i: hue sector 0..5 (6/7 give black), frac_i: position in sector, rgb_o: {r,g,b}.
module ws2811_hue_to_rgb
  import ws2811_pkg::*;
#(
  parameter int COLOR_W = 8
) (
  input  sector_t              sector_i,
  input  logic [COLOR_W-1:0]   frac_i,
  output logic [3*COLOR_W-1:0] rgb_o
);
  localparam logic [COLOR_W-1:0] MAX = '1;
  localparam logic [COLOR_W-1:0] Z   = '0;
  logic [COLOR_W-1:0] dn;
  assign dn = MAX - frac_i;
  always_comb begin
    rgb_o = '0;
    case (sector_i)
      3'd0: rgb_o = {MAX, frac_i, Z};
      3'd1: rgb_o = {dn, MAX, Z};
      3'd2: rgb_o = {Z, MAX, frac_i};
      3'd3: rgb_o = {Z, dn, MAX};
      3'd4: rgb_o = {frac_i, Z, MAX};
      3'd5: rgb_o = {MAX, Z, dn};
      default: rgb_o = '0;
    endcase
  end
endmodule

// File: rtl/ws2811_hsv_pattern_engine.sv
// ws2811_hsv_pattern_engine: animated hue/breathing colour source serving one pixel per request.
// clock, reset_n (async, active-low); bus (slave): advance/period drive the animation divider,
// serial_reset/pixel_req frame the pixel stream, mode/pixel_step/brightness shape the colour,
// rgb/rgb_valid/pixel_index return the served pixel two cycles after its request.
module ws2811_hsv_pattern_engine
  import ws2811_pkg::*;
#(
  parameter int COLOR_W = 8,
  parameter int DIV_W   = 32,
  parameter int N_LEDS  = 50
) (
  input logic clock,
  input logic reset_n,
  ws2811_hsv_pattern_engine_if.slave bus
);
  localparam int IDX_W = $clog2(N_LEDS + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_LEDS);
  localparam logic [COLOR_W-1:0] ONE_C = COLOR_W'(1);
  typedef struct packed {
    sector_t            sector;
    logic [COLOR_W-1:0] frac;
  } hue_t;
  localparam hue_t HUE_ONE = '{sector: 3'd0, frac: ONE_C};
  function automatic hue_t hue_sum(hue_t a, hue_t b);
    logic [COLOR_W:0] f;
    f = {1'b0, a.frac} + {1'b0, b.frac};
    return '{sector: hue_add(a.sector, b.sector, f[COLOR_W]), frac: f[COLOR_W-1:0]};
  endfunction
  // (c * (k+1)) >> COLOR_W: k = MAX reproduces c exactly, product never exceeds 2*COLOR_W bits.
  function automatic logic [COLOR_W-1:0] scale(logic [COLOR_W-1:0] c, logic [COLOR_W-1:0] k);
    logic [2*COLOR_W-1:0] p;
    p = (2*COLOR_W)'(c) * ((2*COLOR_W)'(k) + (2*COLOR_W)'(1));
    return COLOR_W'(p >> COLOR_W);
  endfunction
  mode_e                mode;
  hue_t                 base_q, base_d, pix_q, pix_d, serve;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W:0]       cnt_inc, eff;
  logic                 step;
  logic [IDX_W-1:0]     pcnt_q, pcnt_d, scnt;
  breath_e              br_q;
  logic [COLOR_W-1:0]   lvl_q;
  logic [3*COLOR_W-1:0] raw, scaled, rgb1_q, rgb2_q;
  logic [COLOR_W-1:0]   k1_q;
  logic [IDX_W-1:0]     idx1_q, idx2_q;
  logic                 v1_q, v2_q;
  assign mode = mode_e'(bus.mode);
  ws2811_hue_to_rgb #(.COLOR_W(COLOR_W)) u_h2r (
    .sector_i (serve.sector),
    .frac_i   (serve.frac),
    .rgb_o    (raw)
  );
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + (DIV_W+1)'(1);
    eff     = (bus.period == '0) ? (DIV_W+1)'(1) : {1'b0, bus.period};
    // >= rather than == so lowering period below the running count steps on the next advance.
    step    = bus.advance && (cnt_inc >= eff);
    cnt_d   = !bus.advance ? cnt_q : step ? '0 : cnt_inc[DIV_W-1:0];
    base_d  = (step && (mode == MODE_RAINBOW || mode == MODE_UNIFORM)) ? hue_sum(base_q, HUE_ONE) : base_q;
    // Frame restart takes effect before a same-cycle request and sees the pre-step base hue.
    serve   = bus.serial_reset ? base_q : pix_q;
    scnt    = bus.serial_reset ? '0 : pcnt_q;
    pix_d   = (bus.pixel_req && mode == MODE_RAINBOW) ? hue_sum(serve, hue_t'(bus.pixel_step)) : serve;
    pcnt_d  = (bus.pixel_req && scnt != LAST) ? scnt + IDX_W'(1) : scnt;
    scaled  = '0;
    for (int i = 0; i < 3; i++) scaled[i*COLOR_W +: COLOR_W] = scale(rgb1_q[i*COLOR_W +: COLOR_W], k1_q);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      base_q <= '0;
      pix_q  <= '0;
      pcnt_q <= '0;
      v1_q   <= 1'b0;
      idx1_q <= '0;
      rgb1_q <= '0;
      k1_q   <= '0;
      v2_q   <= 1'b0;
      idx2_q <= '0;
      rgb2_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      base_q <= base_d;
      pix_q  <= pix_d;
      pcnt_q <= pcnt_d;
      v1_q   <= bus.pixel_req;
      if (bus.pixel_req) begin
        idx1_q <= scnt;
        rgb1_q <= (scnt == LAST || mode == MODE_OFF) ? '0 : raw;
        k1_q   <= (mode == MODE_BREATHE) ? lvl_q : bus.brightness;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        idx2_q <= idx1_q;
        rgb2_q <= scaled;
      end
    end
  end
  // Breathing level: ramps up to brightness, back down to 0; clamps if brightness falls below it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      br_q  <= BR_UP;
      lvl_q <= '0;
    end else if (step && mode == MODE_BREATHE) begin
      if (br_q == BR_UP) begin
        lvl_q <= (lvl_q >= bus.brightness) ? bus.brightness : lvl_q + ONE_C;
        if (lvl_q >= bus.brightness || lvl_q + ONE_C == bus.brightness) br_q <= BR_DOWN;
      end else begin
        lvl_q <= (lvl_q > bus.brightness) ? bus.brightness : (lvl_q == '0) ? '0 : lvl_q - ONE_C;
        if (lvl_q <= bus.brightness && lvl_q <= ONE_C) br_q <= BR_UP;
      end
    end
  end
  assign bus.rgb         = rgb2_q;
  assign bus.rgb_valid   = v2_q;
  assign bus.pixel_index = idx2_q;
endmodule

// File: tb/tb_ws2811_hsv_pattern_engine.sv
// tb_ws2811_hsv_pattern_engine: directed table-driven check of the pattern engine.
module tb_ws2811_hsv_pattern_engine;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  ws2811_hsv_pattern_engine_if bus ();
  ws2811_hsv_pattern_engine_if #(.N_LEDS(4)) bus4 ();
  ws2811_hsv_pattern_engine dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  ws2811_hsv_pattern_engine #(.N_LEDS(4)) dut4 (.clock(clock), .reset_n(reset_n), .bus(bus4));
  typedef struct {
    logic        sr;
    logic [1:0]  mode;
    logic [7:0]  bri;
    logic [10:0] step;
    logic [23:0] rgb;
    logic [5:0]  idx;
  } vec_t;
  vec_t vecs[12];
  int n_vec = 0;
  int n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask
  // One isolated request; on return the served pixel is on the outputs (t+2).
  task automatic req1(input logic sr, input logic [1:0] m, input logic [7:0] b, input logic [10:0] s);
    bus.serial_reset = sr;
    bus.pixel_req = 1'b1;
    bus.mode = m;
    bus.brightness = b;
    bus.pixel_step = s;
    tick();
    bus.pixel_req = 1'b0;
    bus.serial_reset = 1'b0;
    chk("early_valid", 32'(bus.rgb_valid), 32'd0);
    tick();
    chk("valid", 32'(bus.rgb_valid), 32'd1);
  endtask
  initial begin
    logic [23:0] rainbow[7];
    logic [7:0]  breath[8];
    logic        seen;
    bus.advance = 0; bus.serial_reset = 0; bus.pixel_req = 0; bus.mode = 2'b01;
    bus.period = 32'd1; bus.pixel_step = '0; bus.brightness = 8'hFF;
    bus4.advance = 0; bus4.serial_reset = 0; bus4.pixel_req = 0; bus4.mode = 2'b01;
    bus4.period = 32'd1; bus4.pixel_step = '0; bus4.brightness = 8'hFF;
    vecs[0]  = '{1'b1, 2'b01, 8'd255, 11'h000, 24'hFF0000, 6'd0};
    vecs[1]  = '{1'b1, 2'b01, 8'd127, 11'h000, 24'h7F0000, 6'd0};
    vecs[2]  = '{1'b1, 2'b01, 8'd0,   11'h000, 24'h000000, 6'd0};
    vecs[3]  = '{1'b0, 2'b11, 8'd255, 11'h000, 24'h000000, 6'd1};
    vecs[4]  = '{1'b0, 2'b00, 8'd255, 11'h200, 24'hFF0000, 6'd2};
    vecs[5]  = '{1'b0, 2'b00, 8'd255, 11'h080, 24'h00FF00, 6'd3};
    vecs[6]  = '{1'b0, 2'b01, 8'd255, 11'h000, 24'h00FF80, 6'd4};
    vecs[7]  = '{1'b0, 2'b00, 8'd255, 11'h580, 24'h00FF80, 6'd5};
    vecs[8]  = '{1'b0, 2'b01, 8'd255, 11'h000, 24'h00FF00, 6'd6};
    vecs[9]  = '{1'b1, 2'b00, 8'd255, 11'h140, 24'hFF0000, 6'd0};
    vecs[10] = '{1'b0, 2'b01, 8'd255, 11'h000, 24'hBFFF00, 6'd1};
    vecs[11] = '{1'b0, 2'b01, 8'd127, 11'h000, 24'h5F7F00, 6'd2};
    rainbow = '{24'hFF0000, 24'hFFFF00, 24'h00FF00, 24'h00FFFF, 24'h0000FF, 24'hFF00FF, 24'hFF0000};
    breath = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};
    tick();
    chk("rst_rgb", 32'(bus.rgb), 32'd0);
    chk("rst_valid", 32'(bus.rgb_valid), 32'd0);
    chk("rst_idx", 32'(bus.pixel_index), 32'd0);
    reset_n = 1'b1;
    tick();
    // Table: per-pixel colour, scaling, off mode, hue carry/wrap, frame restarts.
    for (int i = 0; i < 12; i++) begin
      req1(vecs[i].sr, vecs[i].mode, vecs[i].bri, vecs[i].step);
      chk($sformatf("vec%0d_rgb", i), 32'(bus.rgb), 32'(vecs[i].rgb));
      chk($sformatf("vec%0d_idx", i), 32'(bus.pixel_index), 32'(vecs[i].idx));
    end
    // Back-to-back rainbow, one sector per pixel.
    do_reset();
    bus.mode = 2'b00; bus.pixel_step = 11'h100; bus.brightness = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      bus.pixel_req = (i < 7);
      bus.serial_reset = (i == 0);
      tick();
      if (i >= 1) begin
        chk($sformatf("rb%0d_valid", i - 1), 32'(bus.rgb_valid), 32'd1);
        chk($sformatf("rb%0d_rgb", i - 1), 32'(bus.rgb), 32'(rainbow[i-1]));
        chk($sformatf("rb%0d_idx", i - 1), 32'(bus.pixel_index), 32'(i - 1));
      end
    end
    bus.pixel_req = 1'b0;
    tick();
    chk("rb_done_valid", 32'(bus.rgb_valid), 32'd0);
    // Uniform cycle and divider behaviour.
    do_reset();
    bus.mode = 2'b01; bus.period = 32'd1; bus.advance = 1'b1;
    repeat (255) tick();
    bus.advance = 1'b0;
    req1(1'b1, 2'b01, 8'hFF, 11'h0);
    chk("uni255_rgb", 32'(bus.rgb), 32'hFFFF00);
    chk("uni255_idx", 32'(bus.pixel_index), 32'd0);
    bus.period = 32'd0; bus.advance = 1'b1;
    repeat (2) tick();
    bus.advance = 1'b0;
    req1(1'b1, 2'b01, 8'hFF, 11'h0);
    chk("period0_rgb", 32'(bus.rgb), 32'hFEFF00);
    bus.period = 32'd3; bus.advance = 1'b1;
    repeat (6) tick();
    bus.advance = 1'b0;
    req1(1'b1, 2'b01, 8'hFF, 11'h0);
    chk("period3_rgb", 32'(bus.rgb), 32'hFCFF00);
    bus.period = 32'd10; bus.advance = 1'b1;
    repeat (5) tick();
    bus.period = 32'd2;
    tick();
    bus.advance = 1'b0;
    req1(1'b1, 2'b01, 8'hFF, 11'h0);
    chk("period_drop_rgb", 32'(bus.rgb), 32'hFBFF00);
    // Breathing, brightness 3.
    do_reset();
    bus.period = 32'd1;
    for (int i = 0; i < 8; i++) begin
      req1(1'b1, 2'b10, 8'd3, 11'h0);
      chk($sformatf("breath%0d_rgb", i), 32'(bus.rgb), {8'd0, breath[i], 16'd0});
      bus.advance = 1'b1;
      tick();
      bus.advance = 1'b0;
    end
    // Async reset with a pixel in flight.
    req1(1'b1, 2'b01, 8'hFF, 11'h0);
    bus.pixel_req = 1'b1; bus.serial_reset = 1'b1;
    tick();
    bus.pixel_req = 1'b0; bus.serial_reset = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_rgb", 32'(bus.rgb), 32'd0);
    chk("arst_valid", 32'(bus.rgb_valid), 32'd0);
    #1 reset_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (bus.rgb_valid) seen = 1'b1;
    end
    chk("arst_no_strobe", 32'(seen), 32'd0);
    // Strip-length saturation on the 4-pixel instance.
    for (int i = 0; i < 7; i++) begin
      bus4.pixel_req = (i < 6);
      bus4.serial_reset = (i == 0);
      tick();
      if (i >= 1) begin
        chk($sformatf("n4_%0d_valid", i - 1), 32'(bus4.rgb_valid), 32'd1);
        chk($sformatf("n4_%0d_rgb", i - 1), 32'(bus4.rgb), (i - 1 < 4) ? 32'hFF0000 : 32'd0);
        chk($sformatf("n4_%0d_idx", i - 1), 32'(bus4.pixel_index), (i - 1 < 4) ? 32'(i - 1) : 32'd4);
      end
    end
    bus4.pixel_req = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
